// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for a 5-stage MIPS pipeline.
//
// Keeps a shadow copy of producer info (we, waddr, tnew) for the E, M and W stages,
// plus the consumer source addresses held in E (rs, rt) and M (rt). Forward selects,
// the Tuse/Tnew stall and the mult/div interlock are all combinational on that
// registered state and the current D-stage inputs.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   d_valid                   D stage holds a real instruction
//   d_rs, d_rt                D source addresses
//   d_tuse_rs, d_tuse_rt      cycles until D needs rs/rt (all ones = not used)
//   d_we, d_waddr, d_tnew     D destination info; tnew counted from E entry
//   d_md_start, d_md_div      D starts a mult (div=0) or divide (div=1)
//   d_md_use                  D reads/writes HI/LO
//   flush                     synchronous flush of E and M
//   stall                     freeze F/D, inject a bubble into E
//   fwd_rs_d, fwd_rt_d        D select: 00 regfile, 01 E, 10 M, 11 W
//   fwd_rs_e, fwd_rt_e        E select: 00 none, 10 M, 11 W
//   fwd_rt_m                  M select: 00 none, 11 W
//   md_busy                   mult/div unit busy
//   stall_cnt, fwd_cnt        (FWD_HAZARD_STATS_EN only) wrapping event counters
//
// Build option: define FWD_HAZARD_STATS_EN to add the stall_cnt/fwd_cnt outputs.

module fwd_hazard_unit #(
  parameter int unsigned AW      = 5,
  parameter int unsigned TW      = 2,
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [AW-1:0] d_waddr,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic [1:0]    fwd_rt_m,
  output logic          md_busy
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fwd_cnt
`endif
);

  localparam int unsigned MdMax = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int unsigned CW    = $clog2(MdMax + 1);

  localparam logic [CW-1:0] MulLoad = CW'(MUL_CYC);
  localparam logic [CW-1:0] DivLoad = CW'(DIV_CYC);

  localparam logic [1:0] SelNone = 2'b00;
  localparam logic [1:0] SelE    = 2'b01;
  localparam logic [1:0] SelM    = 2'b10;
  localparam logic [1:0] SelW    = 2'b11;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] waddr;
    logic [TW-1:0] tnew;
  } prod_t;

  prod_t         e_q, e_d, m_q, m_d, w_q, w_d;
  logic [AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, m_rt_q, m_rt_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          hz_raw;
  logic          md_load;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Register 0 is hard-wired, so it never matches any producer.
  function automatic logic prod_hit(input prod_t p, input logic [AW-1:0] src);
    return p.we && (p.waddr == src) && (src != '0);
  endfunction

  // Producer that cannot deliver in time for the consumer's Tuse.
  function automatic logic prod_late(input prod_t p, input logic [AW-1:0] src,
                                     input logic [TW-1:0] tuse);
    return prod_hit(p, src) && (tuse < p.tnew);
  endfunction

  // Youngest matching producer decides: ready gives its select, not-ready blocks
  // the older stages and returns none (the stall logic covers that case).
  function automatic logic [1:0] fwd_sel(input logic use_e, input logic use_m,
                                         input prod_t pe, input prod_t pm, input prod_t pw,
                                         input logic [AW-1:0] src);
    if (use_e && prod_hit(pe, src)) return (pe.tnew == '0) ? SelE : SelNone;
    if (use_m && prod_hit(pm, src)) return (pm.tnew == '0) ? SelM : SelNone;
    if (prod_hit(pw, src))          return (pw.tnew == '0) ? SelW : SelNone;
    return SelNone;
  endfunction

  // Hazard detection and forward selects
  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    hz_raw = prod_late(e_q, d_rs, d_tuse_rs) | prod_late(m_q, d_rs, d_tuse_rs) |
             prod_late(e_q, d_rt, d_tuse_rt) | prod_late(m_q, d_rt, d_tuse_rt);
    stall  = d_valid & (hz_raw | ((d_md_start | d_md_use) & md_busy));
  end

  always_comb begin
    fwd_rs_d = fwd_sel(1'b1, 1'b1, e_q, m_q, w_q, d_rs);
    fwd_rt_d = fwd_sel(1'b1, 1'b1, e_q, m_q, w_q, d_rt);
    fwd_rs_e = fwd_sel(1'b0, 1'b1, e_q, m_q, w_q, e_rs_q);
    fwd_rt_e = fwd_sel(1'b0, 1'b1, e_q, m_q, w_q, e_rt_q);
    fwd_rt_m = fwd_sel(1'b0, 1'b0, e_q, m_q, w_q, m_rt_q);
  end

  // Shadow pipeline next state
  always_comb begin
    w_d      = m_q;
    w_d.tnew = sat_dec(m_q.tnew);
    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    m_rt_d   = e_rt_q;
    e_d.we    = d_we & d_valid;
    e_d.waddr = d_waddr;
    e_d.tnew  = d_tnew;
    e_rs_d   = d_rs;
    e_rt_d   = d_rt;
    if (flush) begin
      // Flush wins over stall; W still drains normally.
      m_d    = '0;
      m_rt_d = '0;
      e_d    = '0;
      e_rs_d = '0;
      e_rt_d = '0;
    end else if (stall) begin
      e_d    = '0;
      e_rs_d = '0;
      e_rt_d = '0;
    end
  end

  // Mult/div busy counter; flush does not abort an operation already issued.
  always_comb begin
    md_load  = d_valid & d_md_start & ~stall & ~flush;
    md_cnt_d = md_cnt_q;
    if (md_load) begin
      md_cnt_d = d_md_div ? DivLoad : MulLoad;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      m_rt_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_rt_q   <= m_rt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic any_fwd;
  assign any_fwd = |{fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall)   stall_cnt <= stall_cnt + 32'd1;
      if (any_fwd) fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid, d_we, d_md_start, d_md_div, d_md_use, flush;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic [11:0] outs;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  fwd_hazard_unit #(.AW(5), .TW(2), .MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_waddr(d_waddr),
    .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .flush(flush), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  // {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy}
  assign outs = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %03h expected %03h", name, got, exp);
  endtask

  // Directed vectors: one row per clock
  typedef struct {
    logic v; logic [4:0] rs, rt; logic [1:0] tur, tut;
    logic we; logic [4:0] wa; logic [1:0] tn;
    logic mds, mdd, mdu, fl;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit v, input int rs, input int rt, input int tur,
                              input int tut, input bit we, input int wa, input int tn,
                              input bit mds, input bit mdd, input bit mdu, input bit fl,
                              input bit s, input int a, input int b, input int c,
                              input int d, input int e, input bit bz);
    vec_t r;
    r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.tur = 2'(tur); r.tut = 2'(tut);
    r.we = we; r.wa = 5'(wa); r.tn = 2'(tn);
    r.mds = mds; r.mdd = mdd; r.mdu = mdu; r.fl = fl;
    r.exp = {s, 2'(a), 2'(b), 2'(c), 2'(d), 2'(e), bz};
    return r;
  endfunction

  task automatic zero_inputs();
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0; d_we = 0;
    d_waddr = 0; d_tnew = 0; d_md_start = 0; d_md_div = 0; d_md_use = 0; flush = 0;
  endtask

  task automatic apply(input vec_t r);
    d_valid = r.v; d_rs = r.rs; d_rt = r.rt; d_tuse_rs = r.tur; d_tuse_rt = r.tut;
    d_we = r.we; d_waddr = r.wa; d_tnew = r.tn; d_md_start = r.mds; d_md_div = r.mdd;
    d_md_use = r.mdu; flush = r.fl;
  endtask

  task automatic set_mfhi();
    zero_inputs();
    d_valid = 1; d_tuse_rs = 3; d_tuse_rt = 3; d_we = 1; d_waddr = 2; d_tnew = 1;
    d_md_use = 1;
  endtask

  // Reference model: entries carry their original Tnew, stage index = age since E entry.
  typedef struct { bit we; int wa; int tn; int rs; int rt; } ent_t;
  ent_t st[3];
  int   cyc;
  int   md_free_at;

  function automatic ent_t bubble();
    ent_t e;
    e.we = 0; e.wa = 0; e.tn = 0; e.rs = 0; e.rt = 0;
    return e;
  endfunction

  function automatic int eff(input int i);
    int t;
    t = st[i].tn - i;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit hit(input int i, input int s);
    return st[i].we && (st[i].wa == s) && (s != 0);
  endfunction

  function automatic logic [1:0] pick(input int s, input int lo);
    for (int i = lo; i < 3; i++) begin
      if (hit(i, s)) return (eff(i) == 0) ? 2'(i + 1) : 2'b00;
    end
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    return cyc < md_free_at;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = 0;
    for (int i = 0; i < 2; i++) begin
      if (hit(i, int'(d_rs)) && (int'(d_tuse_rs) < eff(i))) h = 1;
      if (hit(i, int'(d_rt)) && (int'(d_tuse_rt) < eff(i))) h = 1;
    end
    if ((d_md_start || d_md_use) && m_busy()) h = 1;
    return d_valid && h;
  endfunction

  function automatic logic [11:0] m_outs();
    return {m_stall(), pick(int'(d_rs), 0), pick(int'(d_rt), 0), pick(st[0].rs, 1),
            pick(st[0].rt, 1), pick(st[1].rt, 2), m_busy()};
  endfunction

  task automatic model_step();
    bit   s;
    ent_t n;
    s = m_stall();
    if (d_valid && d_md_start && !s && !flush) md_free_at = cyc + 1 + (d_md_div ? 10 : 5);
    st[2] = st[1];
    if (flush) begin
      st[1] = bubble();
      st[0] = bubble();
    end else begin
      st[1] = st[0];
      if (s) n = bubble();
      else begin
        n.we = d_valid && d_we; n.wa = int'(d_waddr); n.tn = int'(d_tnew);
        n.rs = int'(d_rs); n.rt = int'(d_rt);
      end
      st[0] = n;
    end
    cyc++;
  endtask

  initial begin
    zero_inputs();
    rst_n = 0;
    #2;
    // Reset state: a would-be consumer sees nothing to forward or wait for.
    d_valid = 1; d_rs = 8; d_rt = 8; d_md_use = 1; d_md_start = 1;
    #1 chk("reset", outs, 12'h000);
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Load-use with Tuse=0: stall while lw is in E and M, then forward from W.
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 8, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0, 0));
    // ALU back-to-back: no stall, E consumer takes M, then M consumer takes W.
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3, 0));
    // Priority: $5 in E and W, $7 in M.
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 7, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 3, 0, 0));
    // Zero register producer never stalls or forwards.
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 0, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // Divide then mfhi: 10 stall cycles.
    tbl.push_back(mk(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0, 0, 3, 3, 1, 2, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 2, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    // Flush with lw in E removes its hazard.
    tbl.push_back(mk(1, 0, 0, 3, 3, 1, 8, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // Multiply survives a flush.
    tbl.push_back(mk(1, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    // Async reset in the middle of a divide.
    zero_inputs();
    repeat (4) @(negedge clk);
    d_valid = 1; d_md_start = 1; d_md_div = 1;
    #1 chk("div_issue", outs, 12'h000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_mfhi();
      #1 chk($sformatf("div_busy%0d", i), outs, 12'h801);
    end
    #2 rst_n = 0;
    #1 chk("async_rst", outs, 12'h000);
    zero_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    set_mfhi();
    #1 chk("post_rst", outs, 12'h000);
    zero_inputs();

    // Randomised run against the reference model.
    for (int i = 0; i < 3; i++) st[i] = bubble();
    cyc = 0;
    md_free_at = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      d_valid    = ($urandom_range(0, 3) != 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_we       = 1'($urandom_range(0, 1));
      d_waddr    = 5'($urandom_range(0, 3));
      d_tnew     = 2'($urandom_range(0, 3));
      d_md_start = ($urandom_range(0, 15) == 0);
      d_md_div   = 1'($urandom_range(0, 1));
      d_md_use   = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      #1 chk($sformatf("rand%0d", n), outs, m_outs());
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
